// File: rtl/npc_bus_arbiter_pkg.sv
// Shared types for the IFU/LSU memory-bus arbiter: FSM state encoding and master IDs.
package npc_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_IF = 3'd1,
        REQ_LS = 3'd2,
        RSP_IF = 3'd3,
        RSP_LS = 3'd4
    } arb_state_e;

    localparam logic MID_IF = 1'b0;
    localparam logic MID_LS = 1'b1;

endpackage

// File: rtl/npc_bus_arbiter.sv
// Two-master (IFU, LSU) to one-slave memory-bus arbiter, one transaction outstanding.
// Build option: define YSYX_24080014_ARB_RR_EN for round-robin tie-breaking;
// otherwise the LSU always wins a tie.
module npc_bus_arbiter
    import npc_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_W-1:0]     if_req_addr,
    output logic                  if_resp_valid,

    input  logic                  ls_req_valid,
    output logic                  ls_req_ready,
    input  logic [ADDR_W-1:0]     ls_req_addr,
    input  logic                  ls_req_wen,
    input  logic [DATA_W-1:0]     ls_req_wdata,
    input  logic [DATA_W/8-1:0]   ls_req_wstrb,
    output logic                  ls_resp_valid,

    output logic [DATA_W-1:0]     m_rdata,

    output logic                  s_req_valid,
    input  logic                  s_req_ready,
    output logic [ADDR_W-1:0]     s_req_addr,
    output logic                  s_req_wen,
    output logic [DATA_W-1:0]     s_req_wdata,
    output logic [DATA_W/8-1:0]   s_req_wstrb,
    input  logic                  s_resp_valid,
    input  logic [DATA_W-1:0]     s_resp_rdata
);

    arb_state_e state;
    logic       any_req;
    logic       win;

`ifdef YSYX_24080014_ARB_RR_EN
    // Master that wins the next tie; flips away from whoever was granted last.
    logic       prio;
`endif

    // Pick the winner among currently requesting masters.
    always_comb begin
        any_req = if_req_valid || ls_req_valid;
        win     = ls_req_valid ? MID_LS : MID_IF;
`ifdef YSYX_24080014_ARB_RR_EN
        if (if_req_valid && ls_req_valid) begin
            win = prio;
        end
`endif
    end

    // Arbitration FSM; slave request payload is captured at grant so it is registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            s_req_valid <= 1'b0;
            s_req_addr  <= '0;
            s_req_wen   <= 1'b0;
            s_req_wdata <= '0;
            s_req_wstrb <= '0;
`ifdef YSYX_24080014_ARB_RR_EN
            prio        <= MID_LS;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        s_req_valid <= 1'b1;
`ifdef YSYX_24080014_ARB_RR_EN
                        prio        <= ~win;
`endif
                        if (win == MID_LS) begin
                            state       <= REQ_LS;
                            s_req_addr  <= ls_req_addr;
                            s_req_wen   <= ls_req_wen;
                            s_req_wdata <= ls_req_wdata;
                            s_req_wstrb <= ls_req_wstrb;
                        end else begin
                            state       <= REQ_IF;
                            s_req_addr  <= if_req_addr;
                            s_req_wen   <= 1'b0;
                            s_req_wdata <= '0;
                            s_req_wstrb <= '0;
                        end
                    end
                end
                REQ_IF, REQ_LS: begin
                    if (s_req_ready) begin
                        state       <= (state == REQ_IF) ? RSP_IF : RSP_LS;
                        s_req_valid <= 1'b0;
                        s_req_addr  <= '0;
                        s_req_wen   <= 1'b0;
                        s_req_wdata <= '0;
                        s_req_wstrb <= '0;
                    end
                end
                RSP_IF, RSP_LS: begin
                    if (s_resp_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake and response pass-throughs, gated by the owning state.
    assign if_req_ready  = (state == REQ_IF) && s_req_ready;
    assign ls_req_ready  = (state == REQ_LS) && s_req_ready;
    assign if_resp_valid = (state == RSP_IF) && s_resp_valid;
    assign ls_resp_valid = (state == RSP_LS) && s_resp_valid;
    assign m_rdata       = (if_resp_valid || ls_resp_valid) ? s_resp_rdata : '0;

`ifndef SYNTHESIS
    // A slave response is only legal while a transaction awaits it.
    a_resp_in_rsp: assert property (@(posedge clk) disable iff (rst)
        s_resp_valid |-> (state == RSP_IF || state == RSP_LS));
`endif

endmodule

// File: tb/tb_npc_bus_arbiter.sv
// Directed bench for npc_bus_arbiter; tie-break expectations follow YSYX_24080014_ARB_RR_EN.
module tb_npc_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_resp_valid;
    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [31:0] ls_req_addr;
    logic        ls_req_wen;
    logic [31:0] ls_req_wdata;
    logic [3:0]  ls_req_wstrb;
    logic        ls_resp_valid;
    logic [31:0] m_rdata;
    logic        s_req_valid;
    logic        s_req_ready;
    logic [31:0] s_req_addr;
    logic        s_req_wen;
    logic [31:0] s_req_wdata;
    logic [3:0]  s_req_wstrb;
    logic        s_resp_valid;
    logic [31:0] s_resp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    npc_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_req_addr   (if_req_addr),
        .if_resp_valid (if_resp_valid),
        .ls_req_valid  (ls_req_valid),
        .ls_req_ready  (ls_req_ready),
        .ls_req_addr   (ls_req_addr),
        .ls_req_wen    (ls_req_wen),
        .ls_req_wdata  (ls_req_wdata),
        .ls_req_wstrb  (ls_req_wstrb),
        .ls_resp_valid (ls_resp_valid),
        .m_rdata       (m_rdata),
        .s_req_valid   (s_req_valid),
        .s_req_ready   (s_req_ready),
        .s_req_addr    (s_req_addr),
        .s_req_wen     (s_req_wen),
        .s_req_wdata   (s_req_wdata),
        .s_req_wstrb   (s_req_wstrb),
        .s_resp_valid  (s_resp_valid),
        .s_resp_rdata  (s_resp_rdata)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected end of sequence");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " s_req_valid"},   32'(s_req_valid),   32'h0);
        chk({tag, " s_req_addr"},    s_req_addr,         32'h0);
        chk({tag, " s_req_wen"},     32'(s_req_wen),     32'h0);
        chk({tag, " s_req_wdata"},   s_req_wdata,        32'h0);
        chk({tag, " s_req_wstrb"},   32'(s_req_wstrb),   32'h0);
        chk({tag, " if_req_ready"},  32'(if_req_ready),  32'h0);
        chk({tag, " ls_req_ready"},  32'(ls_req_ready),  32'h0);
        chk({tag, " if_resp_valid"}, 32'(if_resp_valid), 32'h0);
        chk({tag, " ls_resp_valid"}, 32'(ls_resp_valid), 32'h0);
        chk({tag, " m_rdata"},       m_rdata,            32'h0);
    endtask

    initial begin
        logic        exp_ls;
        logic [31:0] exp_addr;

        rst          = 1'b1;
        if_req_valid = 1'b0;
        if_req_addr  = 32'h0;
        ls_req_valid = 1'b0;
        ls_req_addr  = 32'h0;
        ls_req_wen   = 1'b0;
        ls_req_wdata = 32'h0;
        ls_req_wstrb = 4'h0;
        s_req_ready  = 1'b1;
        s_resp_valid = 1'b0;
        s_resp_rdata = 32'h0;

        // Reset state.
        tick();
        tick();
        chk_quiet("reset");
        rst = 1'b0;
        tick();

        // IFU read alone, slave ready at once, response in the second response cycle.
        if_req_valid = 1'b1;
        if_req_addr  = 32'h8000_0000;
        #1;
        chk("t1 no same-cycle req", 32'(s_req_valid), 32'h0);
        tick();
        chk("t1 s_req_valid",  32'(s_req_valid),  32'h1);
        chk("t1 s_req_addr",   s_req_addr,        32'h8000_0000);
        chk("t1 s_req_wen",    32'(s_req_wen),    32'h0);
        chk("t1 s_req_wstrb",  32'(s_req_wstrb),  32'h0);
        chk("t1 if_req_ready", 32'(if_req_ready), 32'h1);
        chk("t1 ls_req_ready", 32'(ls_req_ready), 32'h0);
        tick();
        if_req_valid = 1'b0;
        chk("t1 ready pulse once", 32'(if_req_ready), 32'h0);
        chk("t1 req dropped",      32'(s_req_valid),  32'h0);
        chk("t1 no early resp",    32'(if_resp_valid), 32'h0);
        tick();
        s_resp_valid = 1'b1;
        s_resp_rdata = 32'h0000_0413;
        #1;
        chk("t1 if_resp_valid", 32'(if_resp_valid), 32'h1);
        chk("t1 m_rdata",       m_rdata,            32'h0000_0413);
        chk("t1 ls_resp_valid", 32'(ls_resp_valid), 32'h0);
        tick();
        s_resp_valid = 1'b0;
        s_resp_rdata = 32'h0;
        #1;
        chk_quiet("t1 after");

        // Tie: IFU fetch vs LSU store; LSU first, IFU after one idle bubble.
        if_req_valid = 1'b1;
        if_req_addr  = 32'h8000_0004;
        ls_req_valid = 1'b1;
        ls_req_addr  = 32'h8000_1000;
        ls_req_wen   = 1'b1;
        ls_req_wdata = 32'hDEAD_BEEF;
        ls_req_wstrb = 4'hF;
        tick();
        chk("t2 s_req_valid",  32'(s_req_valid),  32'h1);
        chk("t2 s_req_addr",   s_req_addr,        32'h8000_1000);
        chk("t2 s_req_wen",    32'(s_req_wen),    32'h1);
        chk("t2 s_req_wdata",  s_req_wdata,       32'hDEAD_BEEF);
        chk("t2 s_req_wstrb",  32'(s_req_wstrb),  32'hF);
        chk("t2 ls_req_ready", 32'(ls_req_ready), 32'h1);
        chk("t2 if_req_ready", 32'(if_req_ready), 32'h0);
        tick();
        ls_req_valid = 1'b0;
        ls_req_wen   = 1'b0;
        ls_req_wstrb = 4'h0;
        s_resp_valid = 1'b1;
        s_resp_rdata = 32'h1234_5678;
        #1;
        chk("t2 ls_resp_valid",      32'(ls_resp_valid), 32'h1);
        chk("t2 if_resp_valid",      32'(if_resp_valid), 32'h0);
        chk("t2 if not granted yet", 32'(if_req_ready),  32'h0);
        tick();
        s_resp_valid = 1'b0;
        #1;
        chk("t2 bubble s_req_valid", 32'(s_req_valid),  32'h0);
        chk("t2 bubble if_ready",    32'(if_req_ready), 32'h0);
        tick();
        chk("t2 if s_req_valid",  32'(s_req_valid),  32'h1);
        chk("t2 if s_req_addr",   s_req_addr,        32'h8000_0004);
        chk("t2 if s_req_wen",    32'(s_req_wen),    32'h0);
        chk("t2 if s_req_wstrb",  32'(s_req_wstrb),  32'h0);
        chk("t2 if_req_ready",    32'(if_req_ready), 32'h1);
        tick();
        if_req_valid = 1'b0;
        s_resp_valid = 1'b1;
        s_resp_rdata = 32'h0010_0093;
        #1;
        chk("t2 if_resp_valid", 32'(if_resp_valid), 32'h1);
        chk("t2 if m_rdata",    m_rdata,            32'h0010_0093);
        tick();
        s_resp_valid = 1'b0;

        // Both masters request continuously for four transactions.
        if_req_valid = 1'b1;
        if_req_addr  = 32'h8000_0010;
        ls_req_valid = 1'b1;
        ls_req_addr  = 32'h8000_2000;
        ls_req_wen   = 1'b0;
        for (int k = 0; k < 4; k++) begin
`ifdef YSYX_24080014_ARB_RR_EN
            exp_ls = (k % 2 == 0);
`else
            exp_ls = 1'b1;
`endif
            exp_addr = exp_ls ? 32'h8000_2000 : 32'h8000_0010;
            tick();
            chk($sformatf("t3 grant%0d addr", k),     s_req_addr,         exp_addr);
            chk($sformatf("t3 grant%0d ls_ready", k), 32'(ls_req_ready),  32'(exp_ls));
            chk($sformatf("t3 grant%0d if_ready", k), 32'(if_req_ready),  32'(!exp_ls));
            tick();
            s_resp_valid = 1'b1;
            s_resp_rdata = 32'hA000_0000 + 32'(k);
            #1;
            chk($sformatf("t3 resp%0d ls", k), 32'(ls_resp_valid), 32'(exp_ls));
            chk($sformatf("t3 resp%0d if", k), 32'(if_resp_valid), 32'(!exp_ls));
            tick();
            s_resp_valid = 1'b0;
            if (k == 3) begin
                if_req_valid = 1'b0;
                ls_req_valid = 1'b0;
            end
        end

        // LSU load with the slave stalling acceptance for five cycles.
        s_req_ready  = 1'b0;
        ls_req_valid = 1'b1;
        ls_req_addr  = 32'h8000_3000;
        ls_req_wen   = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4 stall%0d s_req_valid", i), 32'(s_req_valid),  32'h1);
            chk($sformatf("t4 stall%0d s_req_addr", i),  s_req_addr,        32'h8000_3000);
            chk($sformatf("t4 stall%0d ls_ready", i),    32'(ls_req_ready), 32'h0);
            tick();
        end
        s_req_ready = 1'b1;
        #1;
        chk("t4 accept ls_ready", 32'(ls_req_ready), 32'h1);
        chk("t4 accept addr",     s_req_addr,        32'h8000_3000);
        tick();
        ls_req_valid = 1'b0;
        #1;
        chk("t4 accepted ls_ready", 32'(ls_req_ready), 32'h0);

        // Reset while in RSP_LS with a response on the bus.
        s_resp_valid = 1'b1;
        s_resp_rdata = 32'hCAFE_F00D;
        #1;
        chk("t5 pre-reset ls_resp", 32'(ls_resp_valid), 32'h1);
        rst = 1'b1;
        #1;
        chk_quiet("t5 async reset");
        tick();
        chk("t5 late resp dropped", 32'(ls_resp_valid), 32'h0);
        chk("t5 late rdata",        m_rdata,            32'h0);
        s_resp_valid = 1'b0;
        s_resp_rdata = 32'h0;
        rst          = 1'b0;
        tick();
        chk_quiet("t5 after release");
        if_req_valid = 1'b1;
        if_req_addr  = 32'h8000_0020;
        tick();
        chk("t5 if s_req_valid",  32'(s_req_valid),  32'h1);
        chk("t5 if s_req_addr",   s_req_addr,        32'h8000_0020);
        chk("t5 if_req_ready",    32'(if_req_ready), 32'h1);
        tick();
        if_req_valid = 1'b0;
        s_resp_valid = 1'b1;
        s_resp_rdata = 32'h0000_0013;
        #1;
        chk("t5 if_resp_valid", 32'(if_resp_valid), 32'h1);
        chk("t5 m_rdata",       m_rdata,            32'h0000_0013);
        tick();
        s_resp_valid = 1'b0;
        s_resp_rdata = 32'h0;
        #1;
        chk_quiet("t5 end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
